alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter that shares one ALU instance between two independent requesters, e.g. the integer pipeline and a multi-cycle address/shift helper.
- Each port issues operations over a valid/ready request channel and receives results on a registered valid/ready response channel.
- At most one operation enters the ALU per cycle.
- Each port has at most one operation outstanding.

## Interface
- WIDTH, 32: operand and result width; fixed at 32 to match the ALU.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid[1:0]  in  2  per-port request valid.
- req_ready[1:0]  out  2  per-port request ready.
- req_a0, req_a1  in  32  operand a, port 0 and port 1.
- req_b0, req_b1  in  32  operand b, port 0 and port 1.
- req_op0, req_op1  in  3  alu_control code, port 0 and port 1.
- rsp_valid[1:0]  out  2  per-port response valid.
- rsp_ready[1:0]  in  2  per-port response ready.
- rsp_result0, rsp_result1  out  32  registered ALU result.
- rsp_zero0, rsp_zero1  out  1  registered ALU zero flag.
- busy  out  1  high when any rsp_valid is high.

## Operation
- **Slot free.** Each port has one response slot. slot_free[i] = !rsp_valid[i] | rsp_ready[i]; a slot being drained this cycle counts as free.
- **Eligible.** eligible[i] = req_valid[i] & slot_free[i].
- **Grant.**
  - If only one port is eligible, it is granted.
  - If both are eligible, the port not equal to last_grant is granted.
  - If neither is eligible, there is no grant.
- **Ready.** req_ready[i] = grant[i] & slot_free[i]. It is combinational and may depend on req_valid of both ports. A requester must not make req_valid depend on req_ready.
- **Accept.** A request is accepted when req_valid[i] & req_ready[i].
  - The granted port's a/b/op are muxed into the single ALU.
  - On the next edge, result and zero are captured into slot i, rsp_valid[i] is set, and last_grant is set to i.
- **last_grant.** Updates only on accept; idle cycles do not change it.
- **Response.** On rsp_valid[i] & rsp_ready[i] with no new accept for port i, rsp_valid[i] clears. If drain and accept for port i happen in the same cycle, rsp_valid[i] stays high and the slot loads the new result.
- **Holding.** While rsp_valid[i] is high and rsp_ready[i] is low, rsp_result/rsp_zero are held stable.
- **Width rules.** The ALU operates on 32-bit values. Shift amount is b[4:0]. The arbiter never alters operands or results.
- **Reset.** rst_n low at an edge:
  - clears rsp_valid, rsp_result, rsp_zero and busy to 0;
  - sets last_grant to 1, so port 0 wins the first tie;
  - drops any in-flight slot contents.
  - req_ready is 0 while rst_n is low.

## Timing
- Latency is 1 cycle: accept at edge N, rsp_valid high after edge N, visible in cycle N+1.
- Throughput per port: 1 op/cycle if rsp_ready is held high, given no contention.
- Aggregate throughput: 1 op/cycle.
- Contention: with both ports continuously valid and ready, grants alternate 0,1,0,1...
- Backpressure: with rsp_ready[i] low and the slot full, port i is not eligible and the other port receives every grant.
- Starvation bound: an eligible port is granted within 2 cycles.

## Structure
- Shared header alu_defs.vh holds:
  - the alu_control localparams: ALU_ADD=000, ALU_SLL=001, ALU_SLT=010, ALU_SLTU=011, ALU_XOR=100, ALU_SRL=101, ALU_OR=110, ALU_PASSB=111;
  - ALU_W=32.
- Sub-modules: one ALU instance. Arbitration and slots stay in this module; a separate rr_arb2 sub-module is not warranted.

## Test plan
- **Reset.** Hold rst_n low 3 cycles with req_valid=11 -> req_ready=00, rsp_valid=00, busy=0. After release, port 0 is granted first.
- **Single op.** Port 0 SLL, a=1, b=4, rsp_ready0=1 -> rsp_result0=0x10, rsp_zero0=0, one cycle after accept. rsp_valid0 drops the cycle after.
- **Zero flag and pass-through.** Port 1 SRL, a=0x80000000, b=31 -> result 1, zero 0. Then port 1 SLL, a=0, b=3 -> result 0, zero 1. Then op 111, b=0xDEAD0000 -> result 0xDEAD0000.
- **Contention.** Both ports valid every cycle for 6 cycles, rsp_ready=11 -> accepts alternate P0,P1,P0,P1,P0,P1. Each result matches its own port's operands.
- **Backpressure.** Port 0 result pending, rsp_ready0=0 for 4 cycles, both ports requesting ->
  - req_ready0=0 throughout;
  - port 1 is accepted every cycle;
  - rsp_result0 is unchanged.
  - Raising rsp_ready0 makes port 0 accept in the same cycle it drains, and rsp_valid0 stays high.
- **Mid-operation reset.** Assert rst_n low the cycle after an accept -> rsp_valid clears at that edge, no stale response appears afterward, and last_grant=1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: datapath width and the
// alu_control operation encoding.
package alu_arbiter_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SLL   = 3'b001,
        ALU_SLT   = 3'b010,
        ALU_SLTU  = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SRL   = 3'b101,
        ALU_OR    = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for both ports of the shared-ALU arbiter.
// The requester side is the master; the arbiter is the slave.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [ALU_W-1:0] req_a0;
    logic [ALU_W-1:0] req_a1;
    logic [ALU_W-1:0] req_b0;
    logic [ALU_W-1:0] req_b1;
    logic [2:0]       req_op0;
    logic [2:0]       req_op1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [ALU_W-1:0] rsp_result0;
    logic [ALU_W-1:0] rsp_result1;
    logic             rsp_zero0;
    logic             rsp_zero1;
    logic             busy;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result0, rsp_result1, rsp_zero0, rsp_zero1, busy
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_result0, rsp_result1, rsp_zero0, rsp_zero1, busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU shared by both arbiter ports.
// Shift amounts use b[4:0]; zero flags an all-zero result.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       op,
    output logic [ALU_W-1:0] result,
    output logic             zero
);

    always_comb begin
        // NOTE: result gets a default first so no path through the case can infer a latch.
        result = '0;
        case (alu_op_e'(op))
            ALU_ADD:   result = a + b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SLT:   result = {{(ALU_W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(ALU_W-1){1'b0}}, a < b};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> b[4:0];
            ALU_OR:    result = a | b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with one
// registered response slot per port and synchronous active-low reset.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    logic [1:0]       slot_free;
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [1:0]       accept;
    logic             last_grant;

    logic [ALU_W-1:0] alu_a;
    logic [ALU_W-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [ALU_W-1:0] alu_result;
    logic             alu_zero;

    logic [1:0]       rsp_valid_q;
    logic [ALU_W-1:0] result_q [2];
    logic [1:0]       zero_q;

    // A slot being drained this cycle can take a new result on the same edge.
    always_comb begin
        slot_free = ~rsp_valid_q | bus.rsp_ready;
        eligible  = bus.req_valid & slot_free;
        if (eligible == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = eligible;
        end
    end

    assign bus.req_ready = rst_n ? (grant & slot_free) : 2'b00;
    assign accept        = bus.req_valid & bus.req_ready;

    always_comb begin
        alu_a  = grant[1] ? bus.req_a1  : bus.req_a0;
        alu_b  = grant[1] ? bus.req_b1  : bus.req_b0;
        alu_op = grant[1] ? bus.req_op1 : bus.req_op0;
    end

    alu_arbiter_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 2'b00;
            zero_q      <= 2'b00;
            last_grant  <= 1'b1;
            // NOTE: the two-entry slot array is reset as well, so a flushed
            // response reads back as zero rather than stale data.
            for (int i = 0; i < 2; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    rsp_valid_q[i] <= 1'b1;
                    result_q[i]    <= alu_result;
                    zero_q[i]      <= alu_zero;
                end else if (bus.rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
            if (accept[0]) begin
                last_grant <= 1'b0;
            end else if (accept[1]) begin
                last_grant <= 1'b1;
            end
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result0 = result_q[0];
    assign bus.rsp_result1 = result_q[1];
    assign bus.rsp_zero0   = zero_q[0];
    assign bus.rsp_zero1   = zero_q[1];
    assign bus.busy        = |rsp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single ops, zero flag, contention,
// backpressure with same-cycle drain/accept, and mid-operation reset.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op0 = op;
        bus.req_a0  = a;
        bus.req_b0  = b;
    endtask

    task automatic set_p1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op1 = op;
        bus.req_a1  = a;
        bus.req_b1  = b;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset held 3 cycles with both ports requesting.
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        set_p0(3'b000, 32'd5, 32'd7);
        set_p1(3'b100, 32'h0000_00F0, 32'h0000_00FF);
        #1;
        check("reset_req_ready_pre", {30'd0, bus.req_ready}, 32'd0);
        tick();
        tick();
        tick();
        check("reset_req_ready", {30'd0, bus.req_ready}, 32'd0);
        check("reset_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_result0", bus.rsp_result0, 32'd0);

        // Release: tie resolves to port 0 first.
        rst_n         = 1'b1;
        bus.rsp_ready = 2'b11;
        #1;
        check("first_tie_grant", {30'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 2'b00;
        check("first_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
        check("first_result0", bus.rsp_result0, 32'd12);
        check("first_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        check("first_drain", {30'd0, bus.rsp_valid}, 32'd0);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Single op: port 0 SLL 1 << 4.
        set_p0(3'b001, 32'd1, 32'd4);
        bus.req_valid = 2'b01;
        #1;
        check("sll_req_ready", {30'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 2'b00;
        check("sll_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
        check("sll_result0", bus.rsp_result0, 32'h0000_0010);
        check("sll_zero0", {31'd0, bus.rsp_zero0}, 32'd0);
        tick();
        check("sll_drain", {30'd0, bus.rsp_valid}, 32'd0);

        // Port 1 back-to-back: SRL, SLL of zero, PASSB.
        set_p1(3'b101, 32'h8000_0000, 32'd31);
        bus.req_valid = 2'b10;
        tick();
        check("srl_rsp_valid", {30'd0, bus.rsp_valid}, 32'd2);
        check("srl_result1", bus.rsp_result1, 32'd1);
        check("srl_zero1", {31'd0, bus.rsp_zero1}, 32'd0);
        set_p1(3'b001, 32'd0, 32'd3);
        #1;
        check("b2b_req_ready", {30'd0, bus.req_ready}, 32'd2);
        tick();
        check("sll0_result1", bus.rsp_result1, 32'd0);
        check("sll0_zero1", {31'd0, bus.rsp_zero1}, 32'd1);
        set_p1(3'b111, 32'd1234, 32'hDEAD_0000);
        tick();
        bus.req_valid = 2'b00;
        check("passb_result1", bus.rsp_result1, 32'hDEAD_0000);
        check("passb_zero1", {31'd0, bus.rsp_zero1}, 32'd0);
        tick();
        check("passb_drain", {30'd0, bus.rsp_valid}, 32'd0);

        // Contention: last grant was port 1, so grants run P0,P1,P0,P1,P0,P1.
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            set_p0(3'b000, k, 32'h0000_0100);
            set_p1(3'b100, k, 32'hFFFF_0000);
            #1;
            check($sformatf("cont_grant_%0d", k), {30'd0, bus.req_ready},
                  (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check($sformatf("cont_valid_%0d", k), {30'd0, bus.rsp_valid},
                  (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k % 2 == 0) begin
                check($sformatf("cont_result0_%0d", k), bus.rsp_result0, k + 32'h0000_0100);
            end else begin
                check($sformatf("cont_result1_%0d", k), bus.rsp_result1, k ^ 32'hFFFF_0000);
            end
        end
        bus.req_valid = 2'b00;
        tick();

        // Backpressure: park a port 0 result, then stall its response.
        set_p0(3'b000, 32'h11, 32'h22);
        bus.req_valid = 2'b01;
        tick();
        check("bp_load_result0", bus.rsp_result0, 32'h33);
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b11;
        set_p0(3'b000, 32'hAA, 32'd0);
        for (int j = 0; j < 4; j++) begin
            set_p1(3'b000, j, 32'h1000);
            #1;
            check($sformatf("bp_grant_%0d", j), {30'd0, bus.req_ready}, 32'd2);
            tick();
            check($sformatf("bp_valid_%0d", j), {30'd0, bus.rsp_valid}, 32'd3);
            check($sformatf("bp_hold0_%0d", j), bus.rsp_result0, 32'h33);
            check($sformatf("bp_result1_%0d", j), bus.rsp_result1, j + 32'h1000);
        end
        bus.rsp_ready = 2'b11;
        #1;
        check("bp_drain_accept_grant", {30'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 2'b00;
        check("bp_drain_accept_valid", {30'd0, bus.rsp_valid}, 32'd1);
        check("bp_drain_accept_result0", bus.rsp_result0, 32'hAA);
        tick();

        // Mid-operation reset: port 0 accepts (last grant 0), then reset.
        set_p0(3'b000, 32'd1, 32'd1);
        bus.req_valid = 2'b01;
        tick();
        check("mid_pre_valid", {30'd0, bus.rsp_valid}, 32'd1);
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        check("mid_rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        tick();
        check("mid_rst_valid", {30'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_result0", bus.rsp_result0, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n         = 1'b1;
        bus.req_valid = 2'b00;
        tick();
        check("mid_no_stale", {30'd0, bus.rsp_valid}, 32'd0);
        bus.req_valid = 2'b11;
        #1;
        check("mid_last_grant", {30'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
